// File: rtl/oe_brightness_gate.sv
// rtl/oe_brightness_gate.sv - gates matrix_scan output_enable with a frame-synchronous PWM brightness level and post-latch blanking.
// Optional gamma mapping of the requested level is enabled by defining OE_BRIGHTNESS_GAMMA_EN.
module oe_brightness_gate #(
  parameter int LEVEL_WIDTH  = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int ROW_WIDTH    = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   oe_in,
  input  logic                   row_latch_in,
  input  logic [ROW_WIDTH-1:0]   row_address_in,
  input  logic [LEVEL_WIDTH-1:0] level_in,
  input  logic                   level_valid,
  output logic                   oe_out,
  output logic [LEVEL_WIDTH-1:0] level_active,
  output logic                   level_pending,
  output logic                   frame_pulse
);

  localparam int BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_FULL = '1;
  localparam logic [ROW_WIDTH-1:0]   ROW_LAST   = '1;
  localparam logic [BW-1:0]          BLANK_LOAD = BW'(BLANK_CYCLES);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                 state, state_next;
  logic                   oe_prev, latch_prev;
  logic [ROW_WIDTH-1:0]   row_prev;
  logic [LEVEL_WIDTH-1:0] pwm_cnt, pwm_eff;
  logic [BW-1:0]          blank_cnt;
  logic [LEVEL_WIDTH-1:0] level_store, level_mapped;
  logic                   oe_rise, latch_rise, boundary, duty, blank;
  logic                   store_en, apply_en;

`ifdef OE_BRIGHTNESS_GAMMA_EN
  logic [2*LEVEL_WIDTH-1:0] level_sq;
  assign level_sq     = {{LEVEL_WIDTH{1'b0}}, level_in} * {{LEVEL_WIDTH{1'b0}}, level_in};
  assign level_mapped = (level_in == LEVEL_FULL) ? LEVEL_FULL : level_sq[2*LEVEL_WIDTH-1:LEVEL_WIDTH];
`else
  assign level_mapped = level_in;
`endif

  assign oe_rise    = oe_in & ~oe_prev;
  assign latch_rise = row_latch_in & ~latch_prev;
  assign boundary   = (row_prev == ROW_LAST) && (row_address_in == '0);

  // A fresh oe_in interval compares from zero in its very first cycle, so no duty cycle is lost.
  assign pwm_eff = oe_rise ? '0 : pwm_cnt;
  assign duty    = (level_active == LEVEL_FULL) || (pwm_eff < level_active);
  assign blank   = (blank_cnt != '0);

  assign level_pending = (state == PENDING);

  always_comb begin
    state_next = state;
    store_en   = 1'b0;
    apply_en   = 1'b0;
    case (state)
      IDLE: begin
        if (level_valid) begin
          store_en   = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (boundary) apply_en = 1'b1;
        if (level_valid) begin
          store_en   = 1'b1;
          state_next = PENDING;
        end else if (boundary) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      oe_prev      <= 1'b0;
      latch_prev   <= 1'b0;
      row_prev     <= '0;
      pwm_cnt      <= '0;
      blank_cnt    <= '0;
      level_store  <= LEVEL_FULL;
      level_active <= LEVEL_FULL;
      oe_out       <= 1'b0;
      frame_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      oe_prev     <= oe_in;
      latch_prev  <= row_latch_in;
      row_prev    <= row_address_in;
      frame_pulse <= boundary;
      if (oe_in) pwm_cnt <= pwm_eff + LEVEL_WIDTH'(1);
      if (latch_rise) blank_cnt <= BLANK_LOAD;
      else if (blank) blank_cnt <= blank_cnt - BW'(1);
      // Stored value is already mapped, so the boundary apply is a plain copy.
      if (store_en) level_store <= level_mapped;
      if (apply_en) level_active <= level_store;
      oe_out <= oe_in & duty & ~blank;
    end
  end

endmodule

// File: tb/tb_oe_brightness_gate.sv
// tb/tb_oe_brightness_gate.sv - directed self-checking bench for oe_brightness_gate.
module tb_oe_brightness_gate;

  logic       clk_root = 1'b0;
  logic       reset;
  logic       oe_in;
  logic       row_latch_in;
  logic [3:0] row_address_in;
  logic [7:0] level_in;
  logic       level_valid;
  logic       oe_out;
  logic [7:0] level_active;
  logic       level_pending;
  logic       frame_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int highs, lows, first_high;

`ifdef OE_BRIGHTNESS_GAMMA_EN
  localparam logic [7:0] EXP_40 = 8'h10;
  localparam logic [7:0] EXP_80 = 8'h40;
  localparam logic [7:0] EXP_20 = 8'h04;
  localparam logic [7:0] EXP_30 = 8'h09;
`else
  localparam logic [7:0] EXP_40 = 8'h40;
  localparam logic [7:0] EXP_80 = 8'h80;
  localparam logic [7:0] EXP_20 = 8'h20;
  localparam logic [7:0] EXP_30 = 8'h30;
`endif

  always #5 clk_root = ~clk_root;

  oe_brightness_gate dut (
    .clk_in         (clk_root),
    .reset          (reset),
    .oe_in          (oe_in),
    .row_latch_in   (row_latch_in),
    .row_address_in (row_address_in),
    .level_in       (level_in),
    .level_valid    (level_valid),
    .oe_out         (oe_out),
    .level_active   (level_active),
    .level_pending  (level_pending),
    .frame_pulse    (frame_pulse)
  );

  task automatic tick();
    @(posedge clk_root);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic boundary_step();
    row_address_in = 4'hF;
    tick();
    row_address_in = 4'h0;
    tick();
  endtask

  task automatic send_level(input logic [7:0] v);
    level_in    = v;
    level_valid = 1'b1;
    tick();
    level_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; oe_in = 1'b1; row_latch_in = 1'b0;
    row_address_in = 4'h0; level_in = 8'h00; level_valid = 1'b0;

    // reset with oe_in held high
    repeat (3) tick();
    check("reset_oe_out", oe_out, 0);
    check("reset_level_active", level_active, 8'hFF);
    check("reset_pending", level_pending, 0);
    check("reset_frame_pulse", frame_pulse, 0);
    reset = 1'b0;
    tick();
    check("post_reset_oe_out", oe_out, 1);

    // level 0x40 awaiting a frame boundary
    row_address_in = 4'hF;
    tick();
    send_level(8'h40);
    oe_in = 1'b0;
    check("pend_40_pending", level_pending, 1);
    check("pend_40_active_held", level_active, 8'hFF);
    tick();
    row_address_in = 4'h0;
    tick();
    check("apply_40_frame_pulse", frame_pulse, 1);
    check("apply_40_pending", level_pending, 0);
    check("apply_40_active", level_active, EXP_40);
    tick();
    check("frame_pulse_single", frame_pulse, 0);

    // one full PWM period with oe_in high
    oe_in = 1'b1;
    highs = 0; first_high = -1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (oe_out) begin
        highs++;
        if (first_high < 0) first_high = i;
      end
    end
    check("pwm_40_high_count", highs, EXP_40);
    check("pwm_40_first_high", first_high, 0);
    oe_in = 1'b0;
    tick();
    check("pwm_oe_low_follow", oe_out, 0);

    // level 0 keeps oe_out dark through a whole frame
    send_level(8'h00);
    boundary_step();
    check("apply_00_active", level_active, 8'h00);
    highs = 0;
    for (int r = 0; r < 16; r++) begin
      row_address_in = 4'(r);
      for (int i = 0; i < 20; i++) begin
        oe_in        = (i % 6) > 1;
        row_latch_in = (i == 1);
        tick();
        if (oe_out) highs++;
      end
    end
    row_address_in = 4'h0; oe_in = 1'b0; row_latch_in = 1'b0;
    tick();
    check("level_00_dark", highs, 0);
    check("level_00_frame_pulse", frame_pulse, 1);

    // last write wins before a boundary
    send_level(8'h10);
    send_level(8'h80);
    check("pend_80_pending", level_pending, 1);
    boundary_step();
    check("apply_80_active", level_active, EXP_80);
    check("apply_80_pending", level_pending, 0);

    // level_valid coincident with a boundary while pending
    send_level(8'h20);
    row_address_in = 4'hF;
    tick();
    row_address_in = 4'h0;
    send_level(8'hFF);
    check("coinc_pend_active", level_active, EXP_20);
    check("coinc_pend_pending", level_pending, 1);
    check("coinc_pend_frame_pulse", frame_pulse, 1);
    boundary_step();
    check("coinc_pend_then_ff", level_active, 8'hFF);
    check("coinc_pend_then_idle", level_pending, 0);

    // level_valid coincident with a boundary while idle
    row_address_in = 4'hF;
    tick();
    row_address_in = 4'h0;
    send_level(8'h30);
    check("coinc_idle_active_held", level_active, 8'hFF);
    check("coinc_idle_pending", level_pending, 1);
    boundary_step();
    check("coinc_idle_applied", level_active, EXP_30);

    // row jump that is not a wrap from all-ones
    row_address_in = 4'hE;
    tick();
    row_address_in = 4'h0;
    tick();
    check("no_boundary_frame_pulse", frame_pulse, 0);

`ifdef OE_BRIGHTNESS_GAMMA_EN
    send_level(8'h10);
    boundary_step();
    check("gamma_10_active", level_active, 8'h01);
`endif

    // blanking after a row latch at full level
    send_level(8'hFF);
    boundary_step();
    check("full_level_active", level_active, 8'hFF);
    oe_in = 1'b1;
    repeat (3) tick();
    check("full_level_oe_out", oe_out, 1);
    row_latch_in = 1'b1;
    tick();
    check("latch_edge_oe_out", oe_out, 1);
    row_latch_in = 1'b0;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!oe_out) lows++;
      if (i == 0) check("blank_first_low", oe_out, 0);
      if (i == 2) check("blank_release", oe_out, 1);
    end
    check("blank_low_count", lows, 2);

    // reset discards a pending level
    send_level(8'h55);
    check("pre_reset_pending", level_pending, 1);
    reset = 1'b1;
    tick();
    check("mid_reset_pending", level_pending, 0);
    check("mid_reset_active", level_active, 8'hFF);
    check("mid_reset_oe_out", oe_out, 0);
    reset = 1'b0;
    boundary_step();
    check("post_reset_no_apply", level_active, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
